mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage load/store engine: takes the memory operation presented by the EX/MEM register, runs a request/grant/response handshake with the data memory, and produces the aligned, extended `readDataM` that the MEM/WB register captures. It stalls the pipeline while a bus transaction is outstanding. It also generates byte enables and lane-replicated write data for sub-word stores.

## Interface
- `ADDR_W`, 32, data-memory byte-address width (low `ADDR_W` bits of `aluOutM`)
- `clk`  in  1  pipeline clock
- `rst`  in  1  asynchronous, active-low reset
- `memReadM`  in  1  load in M stage
- `memWriteM`  in  1  store in M stage; wins if both are set
- `memSizeM`  in  2  `MEM_SIZE_B`/`_H`/`_W` (00/01/10); 11 is treated as word
- `memSignedM`  in  1  sign-extend sub-word loads
- `aluOutM`  in  32  effective byte address
- `writeDataM`  in  32  store data (rt value)
- `readDataM`  out  32  load result to MEM/WB
- `stallM`  out  1  freeze PC/IF/ID/EX/MEM registers
- `misalignM`  out  1  one-cycle pulse on misaligned access
- `dmem_req`  out  1  bus request
- `dmem_we`  out  1  write request
- `dmem_addr`  out  ADDR_W  word-aligned address (`[1:0]` = 0)
- `dmem_be`  out  4  byte enables
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_gnt`  in  1  request accepted this cycle
- `dmem_rvalid`  in  1  read data valid this cycle
- `dmem_rdata`  in  32  read word

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE, with an op present and aligned: latch addr/be/wdata/we/size/signed/byte offset, go to REQ.
- IDLE, with an op present and misaligned (H with `addr[0]`=1, W with `addr[1:0]`≠0): pulse `misalignM`. No bus request. A load clears `readDataM` to 0. Go to DONE.
- IDLE, no op: stay.
- REQ: `dmem_req`=1 and all bus outputs stable until `dmem_gnt`. On gnt, a write goes to DONE and a read goes to RESP.
- RESP: wait for `dmem_rvalid`. On rvalid, extract the lane, extend, register into `readDataM`, go to DONE.
- DONE: `stallM`=0, so the pipeline advances at this edge. Unconditionally go to IDLE.
- `stallM` = (memReadM|memWriteM) && state≠DONE. It is combinational, so it is high in the same cycle an op first appears.
- Store lanes:
  - B: wdata={4{wd[7:0]}}, be=0001<<off.
  - H: wdata={2{wd[15:0]}}, be=0011<<(2·off[1]).
  - W: wdata=wd, be=1111.
- Load extraction:
  - B: byte at off, sign- or zero-extended.
  - H: half at off[1].
  - W: whole word.
- `readDataM` holds its last value between loads. Stores never change it.
- `dmem_rvalid` outside RESP is ignored. `dmem_gnt` outside REQ is ignored.

## Timing
- Reset values (async, `rst`=0): state IDLE, `readDataM`=0, `misalignM`=0, `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_be`=0, `dmem_wdata`=0. `stallM` follows its equation.
- Bus outputs are registered. `dmem_req` rises the cycle after the op appears.
- Minimum load with gnt and rvalid each in the first possible cycle: 4 cycles in M (IDLE, REQ, RESP, DONE), i.e. 3 stall cycles.
- Minimum store: 3 cycles in M, i.e. 2 stall cycles. Misaligned access: 2 cycles (IDLE, DONE).
- Each extra cycle without gnt or rvalid adds one stall cycle. There is no timeout.
- Back-to-back ops: DONE→IDLE, and the next op is accepted in IDLE the following cycle. There is one bubble-free IDLE cycle per op.
- Reset mid-transaction: return to IDLE and drop `dmem_req` immediately. Any in-flight response after reset is ignored because the FSM is not in RESP.
- `readDataM` is valid in DONE, the edge at which MEM/WB captures it.

## Structure
- `defines.vh` additions:
  - `MEM_SIZE_B`/`_H`/`_W`, `MEM_SIZE_LENGTH` (1:0)
  - FSM encodings `MAU_IDLE`/`REQ`/`RESP`/`DONE` (2 bits)
  - reuse `WORD_WIDTH` and `ZERO_WORD`
- Sub-module `mem_lane_align`, purely combinational:
  - store path: size, off, wd → be, wdata
  - load path: size, signed, off, rdata → extended data
  - misalign flag
- `mem_access_unit` holds the FSM, the latches and the stall logic.

## Test plan
- LW at 0x100, gnt in first REQ cycle, rvalid next cycle with 0xDEADBEEF → `readDataM`=0xDEADBEEF in DONE; `stallM` high for exactly 3 cycles; `dmem_be`=1111.
- LB signed at 0x103, rdata 0x80123456 → `readDataM`=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x202, wd 0x0000ABCD → `dmem_addr`=0x200, `be`=1100, `wdata`=0xABCDABCD, `we`=1; `stallM` high 2 cycles.
- LW at 0x101 → `misalignM` pulses once, `dmem_req` never rises, `readDataM`=0, 1 stall cycle.
- LW with gnt delayed 3 cycles and rvalid delayed 2 → 8 stall cycles; `dmem_addr`/`be` are stable throughout REQ; a spurious rvalid in REQ is ignored.
- `rst` low while in RESP → `dmem_req`=0 and state IDLE immediately; a late rvalid with 0x12345678 leaves `readDataM`=0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory-stage load/store engine: access sizes,
// word constants and the bus-handshake FSM states.
package mem_access_unit_pkg;

  localparam int WORD_WIDTH      = 32;
  localparam int MEM_SIZE_LENGTH = 2;

  localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;

  localparam logic [MEM_SIZE_LENGTH-1:0] MEM_SIZE_B = 2'b00;
  localparam logic [MEM_SIZE_LENGTH-1:0] MEM_SIZE_H = 2'b01;
  localparam logic [MEM_SIZE_LENGTH-1:0] MEM_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    MAU_IDLE = 2'd0,
    MAU_REQ  = 2'd1,
    MAU_RESP = 2'd2,
    MAU_DONE = 2'd3
  } mau_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store byte enables / replicated write data,
// misalignment detection, and load lane extraction with sign/zero extension.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [MEM_SIZE_LENGTH-1:0] i_st_size,
  input  logic [1:0]                 i_st_off,
  input  logic [WORD_WIDTH-1:0]      i_st_wd,
  output logic [3:0]                 o_st_be,
  output logic [WORD_WIDTH-1:0]      o_st_wdata,
  output logic                       o_misalign,
  input  logic [MEM_SIZE_LENGTH-1:0] i_ld_size,
  input  logic                       i_ld_signed,
  input  logic [1:0]                 i_ld_off,
  input  logic [WORD_WIDTH-1:0]      i_ld_rdata,
  output logic [WORD_WIDTH-1:0]      o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    o_st_be    = 4'b1111;
    o_st_wdata = i_st_wd;
    o_misalign = 1'b0;
    case (i_st_size)
      MEM_SIZE_B: begin
        o_st_be    = 4'b0001 << i_st_off;
        o_st_wdata = {4{i_st_wd[7:0]}};
      end
      MEM_SIZE_H: begin
        o_st_be    = i_st_off[1] ? 4'b1100 : 4'b0011;
        o_st_wdata = {2{i_st_wd[15:0]}};
        o_misalign = i_st_off[0];
      end
      default: o_misalign = (i_st_off != 2'b00);  // word, and 11 treated as word
    endcase
  end

  always_comb begin
    w_byte = i_ld_rdata[7:0];
    case (i_ld_off)
      2'd1:    w_byte = i_ld_rdata[15:8];
      2'd2:    w_byte = i_ld_rdata[23:16];
      2'd3:    w_byte = i_ld_rdata[31:24];
      default: w_byte = i_ld_rdata[7:0];
    endcase
    w_half = i_ld_off[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
    case (i_ld_size)
      MEM_SIZE_B: o_ld_data = {{24{i_ld_signed & w_byte[7]}}, w_byte};
      MEM_SIZE_H: o_ld_data = {{16{i_ld_signed & w_half[15]}}, w_half};
      default:    o_ld_data = i_ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: drives a req/gnt/rvalid data-memory bus,
// stalls the pipeline while a transaction is outstanding, and aligns load data.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memReadM,
  input  logic                  memWriteM,
  input  logic [1:0]            memSizeM,
  input  logic                  memSignedM,
  input  logic [31:0]           aluOutM,
  input  logic [31:0]           writeDataM,
  output logic [31:0]           readDataM,
  output logic                  stallM,
  output logic                  misalignM,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_W-1:0]     dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [31:0]           dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [31:0]           dmem_rdata
);

  mau_state_e r_state, w_next;

  logic [MEM_SIZE_LENGTH-1:0] r_size;
  logic                       r_signed;
  logic [1:0]                 r_off;

  logic                  w_op;
  logic                  w_misalign;
  logic [3:0]            w_be;
  logic [WORD_WIDTH-1:0] w_wdata;
  logic [WORD_WIDTH-1:0] w_ld_data;

  assign w_op   = memReadM | memWriteM;
  assign stallM = w_op && (r_state != MAU_DONE);

  mem_lane_align u_align (
    .i_st_size   (memSizeM),
    .i_st_off    (aluOutM[1:0]),
    .i_st_wd     (writeDataM),
    .o_st_be     (w_be),
    .o_st_wdata  (w_wdata),
    .o_misalign  (w_misalign),
    .i_ld_size   (r_size),
    .i_ld_signed (r_signed),
    .i_ld_off    (r_off),
    .i_ld_rdata  (dmem_rdata),
    .o_ld_data   (w_ld_data)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      MAU_IDLE: if (w_op) w_next = w_misalign ? MAU_DONE : MAU_REQ;
      MAU_REQ:  if (dmem_gnt) w_next = dmem_we ? MAU_DONE : MAU_RESP;
      MAU_RESP: if (dmem_rvalid) w_next = MAU_DONE;
      default:  w_next = MAU_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= MAU_IDLE;
      r_size     <= MEM_SIZE_W;
      r_signed   <= 1'b0;
      r_off      <= 2'b00;
      readDataM  <= ZERO_WORD;
      misalignM  <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= 4'b0000;
      dmem_wdata <= ZERO_WORD;
    end else begin
      r_state   <= w_next;
      misalignM <= 1'b0;
      case (r_state)
        MAU_IDLE: begin
          if (w_op && w_misalign) begin
            misalignM <= 1'b1;
            if (!memWriteM) readDataM <= ZERO_WORD;
          end else if (w_op) begin
            // The bus outputs double as the transaction latches and stay
            // frozen until the next accepted op.
            dmem_req   <= 1'b1;
            dmem_we    <= memWriteM;
            dmem_addr  <= {aluOutM[ADDR_W-1:2], 2'b00};
            dmem_be    <= w_be;
            dmem_wdata <= w_wdata;
            r_size     <= memSizeM;
            r_signed   <= memSignedM;
            r_off      <= aluOutM[1:0];
          end
        end
        MAU_REQ:  if (dmem_gnt) dmem_req <= 1'b0;
        MAU_RESP: if (dmem_rvalid) readDataM <= w_ld_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit: stimulus pushes hand-computed
// bus and result expectations; a negedge monitor pops and compares them.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        memReadM, memWriteM, memSignedM;
  logic [1:0]  memSizeM;
  logic [31:0] aluOutM, writeDataM;
  logic [31:0] readDataM;
  logic        stallM, misalignM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } bus_t;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
  } res_t;

  bus_t exp_bus[$];
  res_t exp_res[$];

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .memReadM    (memReadM),
    .memWriteM   (memWriteM),
    .memSizeM    (memSizeM),
    .memSignedM  (memSignedM),
    .aluOutM     (aluOutM),
    .writeDataM  (writeDataM),
    .readDataM   (readDataM),
    .stallM      (stallM),
    .misalignM   (misalignM),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: bus handshakes and DONE-cycle results, sampled on the falling edge.
  initial begin
    bus_t b;
    res_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (dmem_req && dmem_gnt) begin
          if (exp_bus.size() == 0) begin
            check("unexpected_bus_txn", dmem_addr, 32'hFFFF_FFFF);
          end else begin
            b = exp_bus.pop_front();
            check("bus_addr", dmem_addr, b.addr);
            check("bus_be", {28'd0, dmem_be}, {28'd0, b.be});
            check("bus_wdata", dmem_wdata, b.wdata);
            check("bus_we", {31'd0, dmem_we}, {31'd0, b.we});
          end
        end
        if ((memReadM | memWriteM) && !stallM) begin
          if (exp_res.size() == 0) begin
            check("unexpected_done", readDataM, 32'hFFFF_FFFF);
          end else begin
            r = exp_res.pop_front();
            check("readDataM", readDataM, r.rd);
            check("misalignM", {31'd0, misalignM}, {31'd0, r.mis});
          end
        end
      end
    end
  end

  // Issues one op (starting just after a rising edge), plays the memory side
  // with the given gnt/rvalid delays, and counts stall cycles until DONE.
  task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                        input int gnt_dly, input int rv_dly, input logic spur,
                        input logic [3:0] e_be, input logic [31:0] e_wdata,
                        input logic [31:0] e_rd, input logic e_mis, input int e_stalls);
    int stalls = 0, req_wait = 0, rv_wait = 0;
    logic waiting_rv = 1'b0, done = 1'b0, have_ref = 1'b0;
    logic [31:0] ref_addr;
    logic [3:0]  ref_be;
    if (!e_mis) exp_bus.push_back('{addr & ~32'h3, e_be, e_wdata, wr});
    exp_res.push_back('{e_rd, e_mis});
    memReadM = rd; memWriteM = wr; memSizeM = sz; memSignedM = sg;
    aluOutM = addr; writeDataM = wd;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      if (dmem_req) begin
        if (!have_ref) begin
          ref_addr = dmem_addr; ref_be = dmem_be; have_ref = 1'b1;
        end else begin
          check("req_addr_stable", dmem_addr, ref_addr);
          check("req_be_stable", {28'd0, dmem_be}, {28'd0, ref_be});
        end
        if (req_wait == gnt_dly) dmem_gnt = 1'b1;
        else begin
          req_wait++;
          if (spur) begin dmem_rvalid = 1'b1; dmem_rdata = 32'hBAAD_F00D; end
        end
      end else if (waiting_rv) begin
        if (rv_wait == rv_dly) begin
          dmem_rvalid = 1'b1; dmem_rdata = rdata; waiting_rv = 1'b0;
        end else rv_wait++;
      end
      @(negedge clk);
      if (!stallM) done = 1'b1;
      else stalls++;
      if (dmem_gnt && !wr) waiting_rv = 1'b1;
      @(posedge clk); #1;
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    memReadM = 1'b0; memWriteM = 1'b0;
    if (!done) check("op_timeout", 32'd0, 32'd1);
    check("stall_cycles", stalls, e_stalls);
    check("misalign_cleared", {31'd0, misalignM}, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    memReadM = 1'b0; memWriteM = 1'b0; memSizeM = 2'b00; memSignedM = 1'b0;
    aluOutM = '0; writeDataM = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_readDataM", readDataM, 32'd0);
    check("rst_misalignM", {31'd0, misalignM}, 32'd0);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_we", {31'd0, dmem_we}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_be", {28'd0, dmem_be}, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_stall_idle", {31'd0, stallM}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    //     rd   wr   sz     sg    addr          wd            rdata         g  r  sp    be       wdata         exp rd        mis   stalls
    run_op(1'b1,1'b0,2'b10,1'b0,32'h0000_0100,32'h0,       32'hDEAD_BEEF,0, 0, 1'b0, 4'b1111, 32'h0000_0000,32'hDEAD_BEEF,1'b0, 3); // LW
    run_op(1'b1,1'b0,2'b00,1'b1,32'h0000_0103,32'h0,       32'h8012_3456,0, 0, 1'b0, 4'b1000, 32'h0000_0000,32'hFFFF_FF80,1'b0, 3); // LB
    run_op(1'b1,1'b0,2'b00,1'b0,32'h0000_0103,32'h0,       32'h8012_3456,0, 0, 1'b0, 4'b1000, 32'h0000_0000,32'h0000_0080,1'b0, 3); // LBU
    run_op(1'b0,1'b1,2'b01,1'b0,32'h0000_0202,32'h0000_ABCD,32'h0,       0, 0, 1'b0, 4'b1100, 32'hABCD_ABCD,32'h0000_0080,1'b0, 2); // SH
    run_op(1'b1,1'b0,2'b10,1'b0,32'h0000_0101,32'h0,       32'h0,        0, 0, 1'b0, 4'b0000, 32'h0,        32'h0000_0000,1'b1, 1); // LW misaligned
    run_op(1'b1,1'b0,2'b10,1'b0,32'h0000_0300,32'h0,       32'hCAFE_F00D,3, 2, 1'b1, 4'b1111, 32'h0000_0000,32'hCAFE_F00D,1'b0, 8); // LW slow bus
    run_op(1'b1,1'b0,2'b01,1'b1,32'h0000_0402,32'h0,       32'h8001_7FFF,0, 0, 1'b0, 4'b1100, 32'h0000_0000,32'hFFFF_8001,1'b0, 3); // LH
    run_op(1'b1,1'b0,2'b01,1'b0,32'h0000_0400,32'h0,       32'h1234_F00F,0, 1, 1'b0, 4'b0011, 32'h0000_0000,32'h0000_F00F,1'b0, 4); // LHU
    run_op(1'b0,1'b1,2'b00,1'b0,32'h0000_0501,32'h1234_56A5,32'h0,       1, 0, 1'b0, 4'b0010, 32'hA5A5_A5A5,32'h0000_F00F,1'b0, 3); // SB
    run_op(1'b0,1'b1,2'b10,1'b0,32'h0000_0604,32'h1122_3344,32'h0,       0, 0, 1'b0, 4'b1111, 32'h1122_3344,32'h0000_F00F,1'b0, 2); // SW
    run_op(1'b0,1'b1,2'b01,1'b0,32'h0000_0603,32'h0000_5555,32'h0,       0, 0, 1'b0, 4'b0000, 32'h0,        32'h0000_F00F,1'b1, 1); // SH misaligned
    run_op(1'b1,1'b0,2'b11,1'b0,32'h0000_0700,32'h0,       32'h0BAD_C0DE,0, 0, 1'b0, 4'b1111, 32'h0000_0000,32'h0BAD_C0DE,1'b0, 3); // size 11
    run_op(1'b1,1'b1,2'b00,1'b0,32'h0000_0702,32'h0000_00EE,32'h0,       0, 0, 1'b0, 4'b0100, 32'hEEEE_EEEE,32'h0BAD_C0DE,1'b0, 2); // store wins
    run_op(1'b1,1'b0,2'b00,1'b1,32'h0000_0700,32'h0,       32'h0000_007F,0, 0, 1'b0, 4'b0001, 32'h0000_0000,32'h0000_007F,1'b0, 3); // LB positive

    // Reset while waiting in RESP; a late rvalid must be ignored afterwards.
    exp_bus.push_back('{32'h0000_0800, 4'b1111, 32'h0, 1'b0});
    memReadM = 1'b1; memSizeM = 2'b10; memSignedM = 1'b0; aluOutM = 32'h0000_0800; writeDataM = '0;
    @(posedge clk); #1;
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_mid_req", {31'd0, dmem_req}, 32'd0);
    check("rst_mid_readDataM", readDataM, 32'd0);
    check("rst_mid_addr", dmem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    memReadM = 1'b0;
    @(posedge clk); #1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    check("late_rvalid_ignored", readDataM, 32'd0);
    check("late_rvalid_no_req", {31'd0, dmem_req}, 32'd0);

    run_op(1'b1,1'b0,2'b10,1'b0,32'h0000_0104,32'h0,       32'h5A5A_5A5A,0, 0, 1'b0, 4'b1111, 32'h0000_0000,32'h5A5A_5A5A,1'b0, 3); // recovery LW

    repeat (2) @(posedge clk);
    check("bus_queue_drained", exp_bus.size(), 32'd0);
    check("res_queue_drained", exp_res.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
